// File: rtl/pipe_pkg.sv
// pipe_pkg: shared inter-stage widths, control-bit positions and small helpers
package pipe_pkg;
  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_CTRL_W = 9;
  localparam int CB_REG_WRITE = 0;
  localparam int CB_MEM_TO_REG = 1;
  localparam int CB_MEM_READ = 2;
  localparam int CB_MEM_WRITE = 3;
  localparam int CB_ALU_OP_LO = 4;
  localparam int CB_ALU_OP_HI = 6;
  localparam int CB_ALU_SRC = 7;
  localparam int CB_BRANCH = 8;
  function automatic logic [1:0] count2(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction
endpackage

// File: rtl/pipe_entry.sv
// pipe_entry: valid+ctrl+data register; clear wins over load and zeroes ctrl
module pipe_entry #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      ctrl_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      ctrl_q  <= ctrl_i;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign ctrl_o  = ctrl_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry and flush
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);
  logic              o_v, s_v, acc, drain, o_free, o_load, o_clear;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  assign acc    = in_valid & in_ready;
  assign drain  = o_v & out_ready;
  assign o_free = ~o_v | drain;
  assign o_load  = o_free & (s_v | acc);
  assign o_clear = flush | (o_free & ~s_v & ~acc);
  // the skid entry is always older than the input, so it refills the output first
  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_out (
    .clk, .reset,
    .load_i(o_load), .clear_i(o_clear),
    .data_i(s_v ? s_data : in_data), .ctrl_i(s_v ? s_ctrl : in_ctrl),
    .valid_o(o_v), .data_o(out_data), .ctrl_o(out_ctrl)
  );
  generate
    if (SKID) begin : g_skid
      logic in_rdy_q, in_rdy_d, s_load, s_clear, s_v_d;
      assign s_load  = acc & (s_v == o_free);
      assign s_clear = flush | (s_v & o_free & ~acc);
      assign s_v_d   = ~flush & (s_load | (s_v & ~s_clear));
      assign in_rdy_d = ~s_v_d;
      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk, .reset,
        .load_i(s_load), .clear_i(s_clear),
        .data_i(in_data), .ctrl_i(in_ctrl),
        .valid_o(s_v), .data_o(s_data), .ctrl_o(s_ctrl)
      );
      always_ff @(posedge clk) in_rdy_q <= reset ? 1'b1 : in_rdy_d;
      assign in_ready = in_rdy_q & ~reset;
    end else begin : g_single
      assign s_v      = 1'b0;
      assign s_data   = '0;
      assign s_ctrl   = '0;
      assign in_ready = ~reset & (~o_v | out_ready);
    end
  endgenerate
  assign out_valid = o_v;
  assign occupancy = count2(o_v, s_v);
endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width (immediates, operands, PC, register indices).
REQ-002 SHALL have parameter CTRL_W, default 9, control-field width (RegWrite, MemtoReg, MemRead, MemWrite, ALUop, ALUSrc, Branch).
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry skid mode, 0 = single-entry mode.
REQ-004 SHALL have port clk, input, 1, clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1, upstream stage holds a valid instruction.
REQ-007 SHALL have port in_ready, output, 1, stage accepts an instruction this cycle.
REQ-008 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W, upstream control bits.
REQ-010 SHALL have port flush, input, 1, kill all held instructions (branch mispredict or exception).
REQ-011 SHALL have port out_valid, output, 1, downstream copy is valid.
REQ-012 SHALL have port out_ready, input, 1, downstream consumes this cycle (0 = stall).
REQ-013 SHALL have port out_data, output, DATA_W, registered payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W, registered control; all-zero whenever out_valid=0.
REQ-015 SHALL have port occupancy, output, 2, number of held entries (0..2).

Function
REQ-016 SHALL accept when in_valid and in_ready; SHALL deliver when out_valid and out_ready.
REQ-017 SHALL present an accepted instruction on out_* one cycle after acceptance if the output entry is empty or draining that cycle.
REQ-018 SHALL sustain one transfer per cycle with no bubbles while in_valid=1 and out_ready=1.
REQ-019 SKID=1: in_ready SHALL be a registered signal equal to "skid entry empty"; an accept while the output entry is full and not draining SHALL be stored in the skid entry.
REQ-020 SKID=1: when the output entry drains and the skid entry is full, the skid content SHALL move to the output entry in that cycle; a same-cycle accept SHALL go to the skid entry.
REQ-021 SKID=0: in_ready SHALL equal (not out_valid) or out_ready, combinationally; the skid entry SHALL not exist and occupancy SHALL never exceed 1.
REQ-022 Order SHALL be preserved: skid entry content always older than any later accept, never overtaken.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_ctrl SHALL remain stable.
REQ-024 flush SHALL, on that clock edge, clear both entries' valid bits, zero their ctrl fields, and discard any same-cycle input; in_ready SHALL be 1 in the following cycle.
REQ-025 flush SHALL take priority over accept, drain and skid move; data fields need not be cleared.
REQ-026 Invalid entries SHALL carry ctrl=0, so a bubble never writes registers or memory.
REQ-027 occupancy SHALL equal the count of valid entries, updated with the state.

Reset
REQ-028 While reset=1 on a clock edge: out_valid=0, out_data=0, out_ctrl=0, skid entry cleared, occupancy=0.
REQ-029 in_ready SHALL be 0 while reset is asserted and 1 in the first cycle after reset deasserts.
REQ-030 Reset mid-stall SHALL discard held instructions; reset SHALL override flush and all handshakes.

Structure
REQ-031 A shared pipeline package SHALL hold default widths (DATA_W, CTRL_W) and named control-bit index constants, reused by every inter-stage instance (IF/ID, ID/EX, EX/MEM, MEM/WB).
REQ-032 One sub-module, pipe_entry (a valid+ctrl+data register with load and clear), SHALL be instantiated for the output entry and, when SKID=1, for the skid entry.

Verification
REQ-033 Streaming: in_valid=1, out_ready=1, in_data=1,2,3,4 on consecutive cycles -> out_data=1,2,3,4 one cycle later, no gaps, occupancy=1.
REQ-034 Stall (SKID=1): accept A=0xA, B=0xB, then out_ready=0 -> out_data=0xA held, occupancy=2, in_ready=0; out_ready=1 -> 0xA then 0xB delivered in order.
REQ-035 Flush: occupancy=2, flush=1 with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, incoming instruction absent from output.
REQ-036 SKID=0: out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, back-to-back transfer.
REQ-037 Reset mid-operation: occupancy=2, reset=1 for one cycle -> out_valid=0, out_data=0, out_ctrl=0, occupancy=0; in_ready=1 the cycle after.
REQ-038 Random valid/ready with a scoreboard -> no loss, duplication or reordering; ctrl=0 on every cycle out_valid=0.
